ahb_lite_rr_scheduler: RTL

//  Shares one AHB-Lite slave port (the SDRAM controller) between two local requesters.

---
 rtl/ahb_lite_pkg.sv | 20 ++
 rtl/ahb_lite_rr_scheduler_if.sv | 31 +++
 rtl/rr_arbiter2.sv | 10 +
 rtl/ahb_lite_rr_scheduler.sv | 80 ++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: AHB-Lite encodings, scheduler states and address helper
package ahb_lite_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  typedef struct packed {
    logic        id;
    logic [31:0] wdata;
  } cmd_t;
  // keeps the implemented word-aligned bits; 64-bit math so bits=32 is legal
  function automatic logic [31:0] addr_mask(int bits);
    logic [63:0] m;
    m = (64'd1 << bits) - 64'd1;
    return m[31:0] & 32'hFFFF_FFFC;
  endfunction
endpackage

// File: rtl/ahb_lite_rr_scheduler_if.sv
// ahb_lite_rr_scheduler_if: requester channels plus AHB-Lite master bus
interface ahb_lite_rr_scheduler_if;
  logic        req0_valid, req0_ready, req0_write;
  logic [31:0] req0_addr, req0_wdata;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_write;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA, ERRCOUNT;
  logic [2:0]  HBURST, HSIZE;
  logic [1:0]  HTRANS;
  logic        HSEL, HWRITE, HREADY, HRESP;
  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req0_ready, rsp0_valid, rsp0_err, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_err, rsp1_rdata,
    output HADDR, HWDATA, HBURST, HSIZE, HTRANS, HSEL, HWRITE, ERRCOUNT,
    input  HRDATA, HREADY, HRESP
  );
  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req0_ready, rsp0_valid, rsp0_err, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_err, rsp1_rdata,
    input  HADDR, HWDATA, HBURST, HSIZE, HTRANS, HSEL, HWRITE, ERRCOUNT,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way combinational arbiter; ptr names the requester favoured on a tie
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       fixed_prio,
  input  logic       ptr,
  output logic [1:0] grant
);
  assign grant[0] = req[0] & (~req[1] | fixed_prio | ~ptr);
  assign grant[1] = req[1] & ~grant[0];
endmodule

// File: rtl/ahb_lite_rr_scheduler.sv
// ahb_lite_rr_scheduler: shares one AHB-Lite slave between two requesters, one transfer in flight
module ahb_lite_rr_scheduler
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_BITS  = 12,
  parameter bit FIXED_PRIO = 0
) (
  input logic HCLK,
  input logic HRESET,
  ahb_lite_rr_scheduler_if.master bus
);
  localparam logic [31:0] AMASK = addr_mask(ADDR_BITS);
  logic [1:0]  state, req, grant, rsp_valid;
  logic        ptr, win, hwrite, err0, err1;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata, rdata0, rdata1, errcount;
  cmd_t        cmd;
  assign req = {bus.req1_valid, bus.req0_valid} & {2{state == S_IDLE}};
  rr_arbiter2 u_arb (.req(req), .fixed_prio(FIXED_PRIO), .ptr(ptr), .grant(grant));
  assign win = grant[1];
  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.rsp0_valid = rsp_valid[0];
  assign bus.rsp1_valid = rsp_valid[1];
  assign bus.rsp0_rdata = rdata0;
  assign bus.rsp1_rdata = rdata1;
  assign bus.rsp0_err = err0;
  assign bus.rsp1_err = err1;
  assign bus.HADDR = haddr;
  assign bus.HTRANS = htrans;
  assign bus.HWRITE = hwrite;
  assign bus.HWDATA = hwdata;
  assign bus.HBURST = HBURST_SINGLE;
  assign bus.HSIZE = HSIZE_WORD;
  assign bus.HSEL = 1'b1;
  assign bus.ERRCOUNT = errcount;
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= S_IDLE;
      ptr <= 1'b0;
      cmd <= '0;
      htrans <= HTRANS_IDLE;
      haddr <= '0;
      hwrite <= 1'b0;
      hwdata <= '0;
      rsp_valid <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      errcount <= '0;
    end else begin
      rsp_valid <= '0;
      if (|grant) begin
        state <= S_ADDR;
        ptr <= ~win;
        cmd <= '{id: win, wdata: win ? bus.req1_wdata : bus.req0_wdata};
        htrans <= HTRANS_NONSEQ;
        haddr <= (win ? bus.req1_addr : bus.req0_addr) & AMASK;
        hwrite <= win ? bus.req1_write : bus.req0_write;
      end else if (state == S_ADDR && bus.HREADY) begin
        state <= S_DATA;
        htrans <= HTRANS_IDLE;
        hwdata <= cmd.wdata;
      end else if (state == S_DATA && bus.HREADY) begin
        // HRESP is only meaningful once HREADY is high, so the first error cycle is skipped
        state <= S_IDLE;
        rsp_valid[cmd.id] <= 1'b1;
        if (cmd.id) begin
          rdata1 <= hwrite ? 32'h0 : bus.HRDATA;
          err1 <= bus.HRESP;
        end else begin
          rdata0 <= hwrite ? 32'h0 : bus.HRDATA;
          err0 <= bus.HRESP;
        end
        if (bus.HRESP && errcount != 32'hFFFF_FFFF) errcount <= errcount + 32'd1;
      end
    end
  end
endmodule
